filter_chain_mux: RTL

//  Parametrised successor of the video filter selector. N_STAGE filters sit in series, each with a bypass path.

---
 rtl/filt_chain_pkg.sv | 29 ++
 rtl/filter_chain_mux_stage.sv | 43 ++++
 rtl/filter_chain_mux.sv | 119 +++++++++++
 3 files changed

// File: rtl/filt_chain_pkg.sv
// Shared types, defaults and the per-channel reduction helper for the filter chain.
package filt_chain_pkg;

  localparam int CH_W_DEF    = 8;
  localparam int OUT_BPC_DEF = 4;

  typedef struct packed {
    logic [CH_W_DEF-1:0] r;
    logic [CH_W_DEF-1:0] g;
    logic [CH_W_DEF-1:0] b;
  } rgb_t;

  // Reduce a ch_w-bit channel to out_bits: round-half-up with saturation, or plain truncation.
  function automatic logic [31:0] round_sat(input logic [31:0] channel, input int out_bits,
                                            input bit round_en, input int ch_w = CH_W_DEF);
    logic [31:0] maxv;
    logic [31:0] sum;
    int          sh;
    sh   = ch_w - out_bits;
    maxv = (32'd1 << ch_w) - 32'd1;
    sum  = channel;
    if (round_en && sh > 0) begin
      sum = channel + (32'd1 << (sh - 1));
      if (sum > maxv) sum = maxv;
    end
    return sum >> sh;
  endfunction

endpackage

// File: rtl/filter_chain_mux_stage.sv
// One pipeline slice: bypass mux around an external filter, registering pixel plus its tags.
module filter_chain_stage
  import filt_chain_pkg::*;
#(
  parameter int PIX_W   = 3 * CH_W_DEF,
  parameter int HC_W    = 10,
  parameter int VC_W    = 10,
  parameter int N_STAGE = 4,
  parameter int IDX     = 0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               valid,
  input  logic [PIX_W-1:0]   pix,
  input  logic [HC_W-1:0]    hc,
  input  logic [VC_W-1:0]    vc,
  input  logic [N_STAGE-1:0] mask,
  input  logic [PIX_W-1:0]   filt,
  output logic               valid_reg,
  output logic [PIX_W-1:0]   pix_reg,
  output logic [HC_W-1:0]    hc_reg,
  output logic [VC_W-1:0]    vc_reg,
  output logic [N_STAGE-1:0] mask_reg
);

  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_reg <= 1'b0;
      pix_reg   <= '0;
      hc_reg    <= '0;
      vc_reg    <= '0;
      mask_reg  <= '0;
    end else begin
      // Bubbles still register their data; only valid marks them as empty.
      valid_reg <= valid;
      pix_reg   <= mask[IDX] ? filt : pix;
      hc_reg    <= hc;
      vc_reg    <= vc;
      mask_reg  <= mask;
    end
  end

endmodule

// File: rtl/filter_chain_mux.sv
// Series chain of bypassable filter stages with a per-frame enable mask and a final
// round/saturate reduction register.
module filter_chain_mux
  import filt_chain_pkg::*;
#(
  parameter int N_STAGE  = 4,
  parameter int CH_W     = CH_W_DEF,
  parameter int OUT_BPC  = OUT_BPC_DEF,
  parameter int HC_W     = 10,
  parameter int VC_W     = 10,
  parameter int ROUND_EN = 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [N_STAGE-1:0]          sw_en,
  input  logic                        sof,
  input  logic                        in_valid,
  input  logic [3*CH_W-1:0]           pix_in,
  input  logic [HC_W-1:0]             hc_in,
  input  logic [VC_W-1:0]             vc_in,
  output logic [N_STAGE*3*CH_W-1:0]   tap_pix,
  output logic [N_STAGE*HC_W-1:0]     tap_hc,
  output logic [N_STAGE*VC_W-1:0]     tap_vc,
  input  logic [N_STAGE*3*CH_W-1:0]   filt_pix,
  output logic                        out_valid,
  output logic [3*OUT_BPC-1:0]        pix_out,
  output logic [HC_W-1:0]             hc_out,
  output logic [VC_W-1:0]             vc_out,
  output logic [N_STAGE-1:0]          mask_out
);

  localparam int PIX_W = 3 * CH_W;

  logic [N_STAGE-1:0]   frame_mask_reg;
  logic [N_STAGE-1:0]   mask_in;

  // Index 0 is the chain input; index i+1 is the register of stage i.
  logic                 chain_valid [0:N_STAGE];
  logic [PIX_W-1:0]     chain_pix   [0:N_STAGE];
  logic [HC_W-1:0]      chain_hc    [0:N_STAGE];
  logic [VC_W-1:0]      chain_vc    [0:N_STAGE];
  logic [N_STAGE-1:0]   chain_mask  [0:N_STAGE];

  logic [3*OUT_BPC-1:0] pix_red;
  logic                 out_valid_reg;
  logic [3*OUT_BPC-1:0] pix_out_reg;
  logic [HC_W-1:0]      hc_out_reg;
  logic [VC_W-1:0]      vc_out_reg;
  logic [N_STAGE-1:0]   mask_out_reg;

  // The sof pixel itself already uses the freshly requested mask.
  assign mask_in = (sof && in_valid) ? sw_en : frame_mask_reg;

  assign chain_valid[0] = in_valid;
  assign chain_pix[0]   = pix_in;
  assign chain_hc[0]    = hc_in;
  assign chain_vc[0]    = vc_in;
  assign chain_mask[0]  = mask_in;

  generate
    for (genvar gi = 0; gi < N_STAGE; gi++) begin : g_stage
      assign tap_pix[gi*PIX_W +: PIX_W] = chain_pix[gi];
      assign tap_hc[gi*HC_W +: HC_W]    = chain_hc[gi];
      assign tap_vc[gi*VC_W +: VC_W]    = chain_vc[gi];

      filter_chain_stage #(
        .PIX_W  (PIX_W),
        .HC_W   (HC_W),
        .VC_W   (VC_W),
        .N_STAGE(N_STAGE),
        .IDX    (gi)
      ) u_stage (
        .clock    (clock),
        .reset    (reset),
        .valid    (chain_valid[gi]),
        .pix      (chain_pix[gi]),
        .hc       (chain_hc[gi]),
        .vc       (chain_vc[gi]),
        .mask     (chain_mask[gi]),
        .filt     (filt_pix[gi*PIX_W +: PIX_W]),
        .valid_reg(chain_valid[gi+1]),
        .pix_reg  (chain_pix[gi+1]),
        .hc_reg   (chain_hc[gi+1]),
        .vc_reg   (chain_vc[gi+1]),
        .mask_reg (chain_mask[gi+1])
      );
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_reduce
      assign pix_red[gi*OUT_BPC +: OUT_BPC] =
        OUT_BPC'(round_sat(32'(chain_pix[N_STAGE][gi*CH_W +: CH_W]), OUT_BPC, ROUND_EN != 0, CH_W));
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (!reset) begin
      frame_mask_reg <= '0;
      out_valid_reg  <= 1'b0;
      pix_out_reg    <= '0;
      hc_out_reg     <= '0;
      vc_out_reg     <= '0;
      mask_out_reg   <= '0;
    end else begin
      if (sof && in_valid) frame_mask_reg <= sw_en;
      out_valid_reg <= chain_valid[N_STAGE];
      pix_out_reg   <= pix_red;
      hc_out_reg    <= chain_hc[N_STAGE];
      vc_out_reg    <= chain_vc[N_STAGE];
      mask_out_reg  <= chain_mask[N_STAGE];
    end
  end

  assign out_valid = out_valid_reg;
  assign pix_out   = pix_out_reg;
  assign hc_out    = hc_out_reg;
  assign vc_out    = vc_out_reg;
  assign mask_out  = mask_out_reg;

endmodule
